// File: rtl/gpr_pkg.sv
// Shared definitions for the general-purpose register file and its scoreboard.
package gpr_pkg;

    localparam int XLEN_DEFAULT  = 64;
    localparam int NREGS_DEFAULT = 32;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    // Register address at the default register count.
    typedef logic [AW_DEFAULT-1:0] gpr_addr_t;

    // Register 0 is hardwired to zero when zero_reg is set; every other
    // register accepts writes and reservations.
    function automatic logic is_writable(input logic [31:0] addr, input logic zero_reg);
        return !(zero_reg && (addr == 32'd0));
    endfunction

endpackage

// File: rtl/gpr_file_sb_if.sv
// Decode/writeback side bundle of the register file: two read ports, reserve,
// write, hazard and the registered debug views.
interface gpr_file_sb_if #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic                  rs1_en;
    logic [AW-1:0]         rs1_addr;
    logic [XLEN-1:0]       rs1_data;
    logic                  rs2_en;
    logic [AW-1:0]         rs2_addr;
    logic [XLEN-1:0]       rs2_data;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_addr;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  hazard;
    logic [NREGS-1:0]      busy_vec;
    logic [NREGS*XLEN-1:0] debug_gprs;

    // Pipeline side: issues reads, reservations and writebacks.
    modport master (
        output rs1_en, rs1_addr, rs2_en, rs2_addr,
        output rsv_en, rsv_addr, wr_en, wr_addr, wr_data,
        input  rs1_data, rs2_data, hazard, busy_vec, debug_gprs
    );

    // Register file side.
    modport slave (
        input  rs1_en, rs1_addr, rs2_en, rs2_addr,
        input  rsv_en, rsv_addr, wr_en, wr_addr, wr_data,
        output rs1_data, rs2_data, hazard, busy_vec, debug_gprs
    );

endinterface

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by decode on issue,
// cleared by writeback, and the decode-stage hazard derived from it.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rs1_en_i,
    input  logic [AW-1:0]    rs1_addr_i,
    input  logic             rs2_en_i,
    input  logic [AW-1:0]    rs2_addr_i,
    input  logic             rsv_en_i,
    input  logic [AW-1:0]    rsv_addr_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    output logic             hazard_o,
    output logic [NREGS-1:0] busy_vec_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             haz1;
    logic             haz2;

    // Next busy state: a new reservation beats the retirement of the old producer.
    always_comb begin
        // NOTE: start from the held value so every path assigns busy_d and no latch is inferred.
        busy_d = busy_q;
        for (int i = 0; i < NREGS; i++) begin
            if (rsv_en_i && (rsv_addr_i == AW'(i)) && is_writable(32'(i), ZERO_REG != 0)) begin
                busy_d[i] = 1'b1;
            end else if (wr_en_i && (wr_addr_i == AW'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    // Busy bit register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A source stalls only if its producer is still outstanding; a producer
    // retiring in this very cycle is covered by the read bypass.
    assign haz1 = rs1_en_i && busy_q[rs1_addr_i] && !(wr_en_i && (wr_addr_i == rs1_addr_i));
    assign haz2 = rs2_en_i && busy_q[rs2_addr_i] && !(wr_en_i && (wr_addr_i == rs2_addr_i));

    assign hazard_o   = haz1 || haz2;
    assign busy_vec_o = busy_q;

endmodule

// File: rtl/gpr_file_sb.sv
// General-purpose register file: two combinational read ports with writeback
// bypass, one synchronous write port, integrated busy-bit scoreboard.
module gpr_file_sb
    import gpr_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    gpr_file_sb_if.slave  bus
);

    logic [XLEN-1:0] gprs_q [NREGS];
    logic            wr_ok;

    assign wr_ok = bus.wr_en && is_writable(32'(bus.wr_addr), ZERO_REG != 0);

    // Architectural register storage, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is reset explicitly because architectural state
            // must read 0 after reset; this rules out RAM inference by design.
            for (int i = 0; i < NREGS; i++) begin
                gprs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            gprs_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Read port 1: disabled reads and the zero register give 0, writeback bypasses storage.
    always_comb begin
        bus.rs1_data = '0;
        if (bus.rs1_en && is_writable(32'(bus.rs1_addr), ZERO_REG != 0)) begin
            if (wr_ok && (bus.wr_addr == bus.rs1_addr)) begin
                bus.rs1_data = bus.wr_data;
            end else begin
                bus.rs1_data = gprs_q[bus.rs1_addr];
            end
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        bus.rs2_data = '0;
        if (bus.rs2_en && is_writable(32'(bus.rs2_addr), ZERO_REG != 0)) begin
            if (wr_ok && (bus.wr_addr == bus.rs2_addr)) begin
                bus.rs2_data = bus.wr_data;
            end else begin
                bus.rs2_data = gprs_q[bus.rs2_addr];
            end
        end
    end

    // Flat debug view of the stored values only.
    for (genvar g = 0; g < NREGS; g++) begin : g_debug
        assign bus.debug_gprs[g*XLEN +: XLEN] = gprs_q[g];
    end

    gpr_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1_en_i   (bus.rs1_en),
        .rs1_addr_i (bus.rs1_addr),
        .rs2_en_i   (bus.rs2_en),
        .rs2_addr_i (bus.rs2_addr),
        .rsv_en_i   (bus.rsv_en),
        .rsv_addr_i (bus.rsv_addr),
        .wr_en_i    (bus.wr_en),
        .wr_addr_i  (bus.wr_addr),
        .hazard_o   (bus.hazard),
        .busy_vec_o (bus.busy_vec)
    );

endmodule

// File: tb/tb_gpr_file_sb.sv
// Bench for gpr_file_sb: directed scenarios plus a randomised phase, with
// expected values queued at stimulus time and compared when outputs are valid.
module tb_gpr_file_sb;
    import gpr_pkg::*;

    localparam int XL = 64;
    localparam int NR = 32;
    localparam int XS = 32;
    localparam int NS = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    gpr_file_sb_if #(.XLEN(XL), .NREGS(NR)) b64 ();
    gpr_file_sb_if #(.XLEN(XS), .NREGS(NS)) b32 ();

    gpr_file_sb #(.XLEN(XL), .NREGS(NR), .ZERO_REG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b64)
    );

    gpr_file_sb #(.XLEN(XS), .NREGS(NS), .ZERO_REG(1)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b32)
    );

    typedef enum {K_RS1, K_RS2, K_HAZ, K_BUSY, K_DBG, K_S_RS1, K_S_DBG} kind_e;
    typedef struct {
        kind_e       kind;
        int          idx;
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t comb_q[$];
    exp_t edge_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference state for the 64-bit instance.
    logic [63:0]   m_gpr [NR];
    logic [NR-1:0] m_busy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input kind_e k, input int idx);
        case (k)
            K_RS1:   return b64.rs1_data;
            K_RS2:   return b64.rs2_data;
            K_HAZ:   return 64'(b64.hazard);
            K_BUSY:  return 64'(b64.busy_vec);
            K_DBG:   return b64.debug_gprs[idx*XL +: XL];
            K_S_RS1: return 64'(b32.rs1_data);
            K_S_DBG: return 64'(b32.debug_gprs[idx*XS +: XS]);
            default: return 'x;
        endcase
    endfunction

    task automatic push(input bit post, input kind_e k, input int idx, input string tag,
                        input logic [63:0] v);
        exp_t e;
        e.kind = k;
        e.idx  = idx;
        e.tag  = tag;
        e.exp  = v;
        if (post) edge_q.push_back(e);
        else      comb_q.push_back(e);
    endtask

    task automatic drain(input bit post);
        exp_t e;
        if (post) begin
            while (edge_q.size() > 0) begin
                e = edge_q.pop_front();
                check(e.tag, observe(e.kind, e.idx), e.exp);
            end
        end else begin
            while (comb_q.size() > 0) begin
                e = comb_q.pop_front();
                check(e.tag, observe(e.kind, e.idx), e.exp);
            end
        end
    endtask

    task automatic drv(input logic r1e, input gpr_addr_t r1a, input logic r2e, input gpr_addr_t r2a,
                       input logic rve, input gpr_addr_t rva, input logic we, input gpr_addr_t wa,
                       input logic [63:0] wd);
        b64.rs1_en   = r1e;
        b64.rs1_addr = r1a;
        b64.rs2_en   = r2e;
        b64.rs2_addr = r2a;
        b64.rsv_en   = rve;
        b64.rsv_addr = rva;
        b64.wr_en    = we;
        b64.wr_addr  = wa;
        b64.wr_data  = wd;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_gpr[i] = '0;
        m_busy = '0;
    endtask

    function automatic logic [63:0] m_read(input logic en, input gpr_addr_t a);
        if (!en || a == '0) return '0;
        if (b64.wr_en && b64.wr_addr == a) return b64.wr_data;
        return m_gpr[a];
    endfunction

    function automatic logic m_haz(input logic en, input gpr_addr_t a);
        return en && m_busy[a] && !(b64.wr_en && b64.wr_addr == a);
    endfunction

    task automatic m_edge();
        logic [NR-1:0] nb;
        nb = m_busy;
        for (int i = 0; i < NR; i++) begin
            if (b64.rsv_en && b64.rsv_addr == gpr_addr_t'(i) && i != 0) nb[i] = 1'b1;
            else if (b64.wr_en && b64.wr_addr == gpr_addr_t'(i))        nb[i] = 1'b0;
        end
        if (b64.wr_en && b64.wr_addr != '0) m_gpr[b64.wr_addr] = b64.wr_data;
        m_busy = nb;
    endtask

    // One clock cycle with inputs already driven: combinational checks before
    // the edge, registered checks just after it.
    task automatic cycle(input string tag);
        #3;
        push(0, K_RS1, 0, {tag, ".rs1"}, m_read(b64.rs1_en, b64.rs1_addr));
        push(0, K_RS2, 0, {tag, ".rs2"}, m_read(b64.rs2_en, b64.rs2_addr));
        push(0, K_HAZ, 0, {tag, ".haz"},
             64'(m_haz(b64.rs1_en, b64.rs1_addr) || m_haz(b64.rs2_en, b64.rs2_addr)));
        drain(0);
        m_edge();
        push(1, K_BUSY, 0, {tag, ".busy"}, 64'(m_busy));
        @(posedge clk);
        #1;
        drain(1);
    endtask

    function automatic gpr_addr_t rnd_addr();
        if ($urandom_range(0, 3) == 0) return gpr_addr_t'($urandom_range(0, NR - 1));
        return gpr_addr_t'($urandom_range(0, 7));
    endfunction

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, '0);
        b32.rs1_en = 1'b0; b32.rs1_addr = '0; b32.rs2_en = 1'b0; b32.rs2_addr = '0;
        b32.rsv_en = 1'b0; b32.rsv_addr = '0; b32.wr_en  = 1'b0; b32.wr_addr  = '0;
        b32.wr_data = '0;
        model_reset();

        // Reset state.
        #12;
        drv(1, 5, 1, 3, 0, 0, 0, 0, '0);
        #1;
        push(0, K_RS1, 0, "rst.rs1", 64'h0);
        push(0, K_RS2, 0, "rst.rs2", 64'h0);
        push(0, K_HAZ, 0, "rst.haz", 64'h0);
        push(0, K_BUSY, 0, "rst.busy", 64'h0);
        drain(0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write x3 with same-cycle bypass on rs2; x15 on the narrow instance with rs1 disabled.
        drv(0, 0, 1, 3, 0, 0, 1, 3, 64'h1234_5678_9ABC_DEF0);
        b32.wr_en = 1'b1; b32.wr_addr = 4'd15; b32.wr_data = 32'hCAFE_BABE;
        b32.rs1_en = 1'b0; b32.rs1_addr = 4'd15;
        push(0, K_RS2, 0, "t2.bypass", 64'h1234_5678_9ABC_DEF0);
        push(0, K_S_RS1, 0, "t6.rs1_disabled", 64'h0);
        push(1, K_S_DBG, 15, "t6.dbg15", 64'hCAFE_BABE);
        cycle("t2a");
        drv(1, 3, 0, 0, 0, 0, 0, 0, '0);
        b32.wr_en = 1'b0; b32.rs1_en = 1'b1;
        push(0, K_RS1, 0, "t2.read", 64'h1234_5678_9ABC_DEF0);
        push(0, K_S_RS1, 0, "t6.read15", 64'hCAFE_BABE);
        push(1, K_DBG, 3, "t2.dbg3", 64'h1234_5678_9ABC_DEF0);
        cycle("t2b");
        b32.rs1_en = 1'b0;

        // Zero register: write and reserve are both dropped.
        drv(1, 0, 1, 0, 1, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        push(0, K_RS1, 0, "t3.rs1_x0", 64'h0);
        push(0, K_HAZ, 0, "t3.haz", 64'h0);
        push(1, K_BUSY, 0, "t3.busy0", 64'h0);
        push(1, K_DBG, 0, "t3.dbg0", 64'h0);
        cycle("t3a");
        drv(1, 0, 0, 0, 0, 0, 0, 0, '0);
        push(0, K_RS1, 0, "t3.rs1_after", 64'h0);
        push(0, K_HAZ, 0, "t3.haz_after", 64'h0);
        cycle("t3b");

        // Hazard on x7 until its writeback, which bypasses and releases.
        drv(0, 0, 0, 0, 1, 7, 0, 0, '0);
        cycle("t4.rsv");
        drv(1, 7, 0, 0, 0, 0, 0, 0, '0);
        push(0, K_HAZ, 0, "t4.haz_n1", 64'h1);
        cycle("t4.n1");
        push(0, K_HAZ, 0, "t4.haz_n2", 64'h1);
        push(1, K_BUSY, 0, "t4.busy_n2", 64'h80);
        cycle("t4.n2");
        drv(1, 7, 0, 0, 0, 0, 1, 7, 64'h42);
        push(0, K_HAZ, 0, "t4.haz_wb", 64'h0);
        push(0, K_RS1, 0, "t4.rs1_wb", 64'h42);
        push(1, K_BUSY, 0, "t4.busy_after", 64'h0);
        push(1, K_DBG, 7, "t4.dbg7", 64'h42);
        cycle("t4.wb");

        // Set wins over clear on x9.
        drv(0, 0, 0, 0, 1, 9, 0, 0, '0);
        cycle("t5.rsv");
        drv(1, 9, 0, 0, 1, 9, 1, 9, 64'h11);
        push(0, K_RS1, 0, "t5.rs1_bypass", 64'h11);
        push(0, K_HAZ, 0, "t5.haz", 64'h0);
        push(1, K_BUSY, 0, "t5.busy9", 64'h200);
        push(1, K_DBG, 9, "t5.dbg9", 64'h11);
        cycle("t5.both");
        drv(0, 0, 0, 0, 0, 0, 1, 9, 64'h22);
        push(1, K_BUSY, 0, "t5.released", 64'h0);
        cycle("t5.rel");

        // Asynchronous reset in mid-cycle after x5 is written and reserved.
        drv(0, 0, 0, 0, 1, 5, 1, 5, 64'hDEAD);
        push(1, K_DBG, 5, "t1.dbg5_before", 64'hDEAD);
        push(1, K_BUSY, 0, "t1.busy_before", 64'h20);
        cycle("t1.wr");
        drv(1, 5, 0, 0, 0, 0, 0, 0, '0);
        #2;
        push(0, K_RS1, 0, "t1.rs1_before", 64'hDEAD);
        drain(0);
        rst_n = 1'b0;
        #1;
        push(0, K_RS1, 0, "t1.rs1_reset", 64'h0);
        push(0, K_BUSY, 0, "t1.busy_reset", 64'h0);
        push(0, K_HAZ, 0, "t1.haz_reset", 64'h0);
        push(0, K_DBG, 5, "t1.dbg5_reset", 64'h0);
        drain(0);
        model_reset();
        drv(0, 0, 0, 0, 0, 0, 0, 0, '0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomised traffic concentrated on a few registers.
        for (int c = 0; c < 300; c++) begin
            drv(1'($urandom_range(0, 1)), rnd_addr(), 1'($urandom_range(0, 1)), rnd_addr(),
                1'($urandom_range(0, 1)), rnd_addr(), 1'($urandom_range(0, 1)), rnd_addr(),
                {$urandom(), $urandom()});
            cycle($sformatf("rnd%0d", c));
        end

        drv(0, 0, 0, 0, 0, 0, 0, 0, '0);
        #3;
        for (int i = 0; i < NR; i++) begin
            push(0, K_DBG, i, $sformatf("end.dbg%0d", i), m_gpr[i]);
        end
        drain(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gpr_file_sb.md
Name: gpr_file_sb

Overview:
Parametrised general-purpose register file for the pipelined core, generalised in data width and register count. It has two combinational read ports with write-to-read bypass and one synchronous write port. An integrated scoreboard tracks one pending-write busy bit per register and produces the decode-stage hazard/stall signal. It sits between decode (read, reserve) and writeback (write, release), and exports a flat debug view for the simulation harness.

Parameters:
XLEN, 64, data width in bits.
NREGS, 32, number of architectural registers; power of two, at least 2.
AW, $clog2(NREGS), register address width (derived; not overridable).
ZERO_REG, 1, when 1 register 0 reads as 0, cannot be written and is never busy.

Ports:
clk  in  1  core clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
rs1_en  in  1  read port 1 enable.
rs1_addr  in  AW  read port 1 address.
rs1_data  out  XLEN  read port 1 data.
rs2_en  in  1  read port 2 enable.
rs2_addr  in  AW  read port 2 address.
rs2_data  out  XLEN  read port 2 data.
rsv_en  in  1  reserve request: mark rsv_addr busy (instruction issued).
rsv_addr  in  AW  destination register being reserved.
wr_en  in  1  writeback write enable; also releases the busy bit.
wr_addr  in  AW  writeback register address.
wr_data  in  XLEN  writeback data.
hazard  out  1  an enabled source register is busy and not being written this cycle.
busy_vec  out  NREGS  per-register busy bits.
debug_gprs  out  NREGS*XLEN  flat register contents; register i occupies bits [i*XLEN +: XLEN].

Behaviour:
- Reset (rst_n low, asynchronous): all registers are set to 0 and all busy bits to 0, immediately. Outputs then read 0, hazard=0, busy_vec=0. Reset has priority over every clocked event. Any write or reserve requested in the cycle rst_n is released is still ignored until the next rising edge.
- Write: on the rising edge, when wr_en=1 and the address is writable, wr_data goes to gprs[wr_addr]. With ZERO_REG=1, address 0 is never writable and a write to it is silently dropped.
- Read (combinational, 0 latency):
  - rsN_en=0 gives rsN_data=0.
  - Otherwise, if wr_en=1, wr_addr==rsN_addr and the address is writable, rsN_data=wr_data (bypass).
  - Otherwise rsN_data=gprs[rsN_addr].
  - Address 0 with ZERO_REG=1 always reads 0.
- Scoreboard, per register i, on the rising edge:
  - set_i = rsv_en && rsv_addr==i && writable(i).
  - clr_i = wr_en && wr_addr==i.
  - set_i=1 gives busy_i=1 (set wins over clear: a new producer reserves while the old one retires).
  - Otherwise clr_i=1 gives busy_i=0.
  - Otherwise busy_i holds.
- hazard = (rs1_en && busy[rs1_addr] && !(wr_en && wr_addr==rs1_addr)) || the same term for rs2. Busy bits for register 0 are always 0 when ZERO_REG=1.
- The reserve in the current cycle does not affect hazard in the same cycle; the busy bit is visible from the next cycle.
- Releasing a non-busy register is legal and leaves it non-busy. Reserving an already busy register keeps it busy (no counting).
- Simultaneous rsv, write and read of the same address in one cycle:
  - reads return the bypassed wr_data;
  - hazard is 0 for that source;
  - busy=1 after the edge.
- busy_vec and debug_gprs reflect registered state only (no bypass).

Decomposition:
- Shared package gpr_pkg holds:
  - default XLEN and NREGS localparams;
  - the register address typedef;
  - a function is_writable(addr, zero_reg).
- One sub-module, gpr_scoreboard: busy bits, set/clear priority and hazard generation. The storage array and bypass muxes stay in gpr_file_sb.

Test Plan:
1. Reset: assert rst_n=0 mid-simulation after writing x5=0xDEAD -> immediately (no clock) rs1_data of x5 = 0 and busy_vec = 0.
2. Write then read: wr x3=0x1234_5678_9ABC_DEF0 at edge N -> rs1_addr=3 reads that value after edge N. In the same cycle as the write, rs2_addr=3 with wr_en=1 reads wr_data (bypass).
3. x0 protection (ZERO_REG=1): wr x0=0xFFFF_FFFF_FFFF_FFFF plus rsv x0 -> rs1 of x0 = 0, busy_vec[0]=0, hazard=0.
4. Hazard: rsv x7 at edge N, then read rs1=7 at cycle N+1 -> hazard=1. Writeback x7=0x42 at cycle N+3 -> in that cycle hazard=0 and rs1_data=0x42; after the edge busy_vec[7]=0.
5. Set-wins: x9 busy; in one cycle wr_en x9=0x11 and rsv_en x9 -> after the edge busy_vec[9]=1 and gprs[9]=0x11.
6. Parameter sweep XLEN=32, NREGS=16: write x15=0xCAFEBABE -> debug_gprs[15*32 +: 32]=0xCAFEBABE. Read disabled (rs1_en=0) -> rs1_data=0.
